// File: rtl/lab2_proc_inst_queue.sv
// Fetch-to-decode instruction queue: buffers imem responses, gates fetch
// with credits and discards stale responses after a redirect.
module lab2_proc_inst_queue #(
  parameter int DEPTH        = 2,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imemreq_fire,
  output logic        imemreq_credit,
  input  logic        imemresp_val,
  output logic        imemresp_rdy,
  input  logic [31:0] imemresp_data,
  input  logic        squash,
  output logic        inst_val_D,
  input  logic        inst_rdy_D,
  output logic [31:0] inst_D,
  output logic        drop_pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int SW = CW + IW + 1;

  logic [31:0]   storage [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [IW-1:0] inflight;
  logic [IW-1:0] drop_cnt;
  logic [IW-1:0] live;
  logic [SW-1:0] occ;
  logic          resp_fire;
  logic          deq;
  logic          enq;
  logic          drop;

  assign drop_pending = (drop_cnt != '0);
  assign imemresp_rdy = drop_pending
                      | (count < CW'(DEPTH));
  assign resp_fire    = imemresp_val & imemresp_rdy;

  // Requests already doomed by a squash do not consume queue space.
  assign live = inflight - drop_cnt;
  assign occ  = SW'(count) + SW'(live);

  assign imemreq_credit = (occ < SW'(DEPTH))
                        & (inflight < IW'(MAX_INFLIGHT));

  assign inst_val_D = (count != '0);
  assign inst_D     = inst_val_D ? storage[head] : 32'h0;

  assign deq  = inst_val_D & inst_rdy_D & ~squash;
  assign enq  = resp_fire & ~drop_pending & ~squash;
  assign drop = resp_fire & drop_pending;

  always_ff @(posedge clk) begin
    if (enq) storage[tail] <= imemresp_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight
                + IW'(imemreq_fire)
                - IW'(resp_fire);
      if (squash) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        // A request fired this cycle targets the new PC and survives.
        drop_cnt <= inflight - IW'(resp_fire);
      end else begin
        if (enq) tail <= tail + 1'b1;
        if (deq) head <= head + 1'b1;
        unique case ({enq, deq})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        if (drop) drop_cnt <= drop_cnt - IW'(1);
      end
    end
  end

  a_credit: assert property (
    @(posedge clk) disable iff (!reset)
    imemreq_fire |-> imemreq_credit
  );

  a_resp: assert property (
    @(posedge clk) disable iff (!reset)
    imemresp_val |-> (inflight != '0)
  );

endmodule
